// File: rtl/unidade_entrada.sv
// Input-port controller: stalls the CPU on an input instruction, waits for a debounced
// confirm press, latches the switch word and pulses pronto. Optional wait timeout: ENTRADA_TIMEOUT_EN.
module unidade_entrada #(
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [DATA_W-1:0] chaves,
  input  logic              botao,
  output logic [DATA_W-1:0] dado,
  output logic              pronto,
  output logic              parar,
  output logic              expirou,
  output logic [2:0]        estado_dbg
);

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    ESPERA_SOLTO  = 3'd1,
    ESPERA_APERTO = 3'd2,
    CAPTURA       = 3'd3,
    FIM           = 3'd4
  } estado_t;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  estado_t           estado_q, estado_d;
  logic [DATA_W-1:0] dado_q, dado_d;
  logic              s1_q, s2_q;
  logic              deb_q, deb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Debounce: the level changes only after CNT_MAX+1 consecutive differing samples.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (s2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

`ifdef ENTRADA_TIMEOUT_EN
  localparam logic [31:0] TO_MAX = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] espera_q, espera_d;
  logic        expirou_q, expirou_d;

  assign espera_d = (estado_q == ESPERA_APERTO) ? espera_q + 32'd1 : 32'd0;
  assign expirou  = expirou_q;
`else
  assign expirou = 1'b0;
`endif

  always_comb begin
    estado_d = estado_q;
    dado_d   = dado_q;
`ifdef ENTRADA_TIMEOUT_EN
    expirou_d = 1'b0;
`endif
    case (estado_q)
      OCIOSO: begin
        if (req) estado_d = ESPERA_SOLTO;
      end
      ESPERA_SOLTO: begin
        // A press still held from the previous input must be released first.
        if (!req)        estado_d = OCIOSO;
        else if (!deb_q) estado_d = ESPERA_APERTO;
      end
      ESPERA_APERTO: begin
        if (!req) begin
          estado_d = OCIOSO;
        end else if (deb_q) begin
          estado_d = CAPTURA;
          dado_d   = chaves;
        end
`ifdef ENTRADA_TIMEOUT_EN
        else if (espera_q == TO_MAX) begin
          estado_d  = CAPTURA;
          dado_d    = '0;
          expirou_d = 1'b1;
        end
`endif
      end
      CAPTURA: begin
        estado_d = FIM;
      end
      FIM: begin
        if (!req) estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      dado_q   <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      deb_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef ENTRADA_TIMEOUT_EN
      espera_q  <= 32'd0;
      expirou_q <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      dado_q   <= dado_d;
      s1_q     <= botao;
      s2_q     <= s1_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
`ifdef ENTRADA_TIMEOUT_EN
      espera_q  <= espera_d;
      expirou_q <= expirou_d;
`endif
    end
  end

  assign dado       = dado_q;
  assign pronto     = (estado_q == CAPTURA);
  // Combinational in req so the stall starts the same cycle the instruction arrives.
  assign parar      = req & ((estado_q == OCIOSO) | (estado_q == ESPERA_SOLTO) |
                             (estado_q == ESPERA_APERTO));
  assign estado_dbg = estado_q;

endmodule

// File: tb/tb_unidade_entrada.sv
// Randomized bench for unidade_entrada with a transaction-level reference model and a
// pronto-driven scoreboard. Honours ENTRADA_TIMEOUT_EN like the design.
module tb_unidade_entrada;

  localparam int W = 16;
  localparam int D = 4;
  localparam int T = 20;
`ifdef ENTRADA_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, req, botao;
  logic [W-1:0] chaves;
  logic [W-1:0] dado;
  logic         pronto, parar, expirou;
  logic [2:0]   estado_dbg;

  unidade_entrada #(.DATA_W(W), .DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .chaves(chaves), .botao(botao),
    .dado(dado), .pronto(pronto), .parar(parar), .expirou(expirou),
    .estado_dbg(estado_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle)", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Operation-level view: an operation starts when req is seen, must observe a released
  // button, then takes the first debounced press (or the timeout), then is served until req drops.
  int           cyc = 0;
  bit           mon_en = 1'b0;
  logic         b1, b2, deb_m;
  int           run_m;
  bit           in_op, armed, served, pulse, exp_m;
  int           wait_n;
  logic [W-1:0] dado_m;
  logic [48:0]  exp_q[$];

  task automatic capture(input logic [W-1:0] v, input bit e);
    pulse  = 1'b1;
    exp_m  = e;
    dado_m = v;
    exp_q.push_back({cyc[31:0], e, v});
  endtask

  initial begin : model
    logic old_deb, s2_pre;
    forever begin
      @(posedge clk);
      cyc++;
      old_deb = deb_m;
      s2_pre  = b2;
      if (!rst_n) begin
        in_op = 0; armed = 0; served = 0; pulse = 0; exp_m = 0; wait_n = 0;
        dado_m = '0; b1 = 0; b2 = 0; deb_m = 0; run_m = 0;
      end else begin
        exp_m = 1'b0;
        if (pulse) begin
          pulse  = 1'b0;
          served = 1'b1;
        end else if (!in_op) begin
          if (req) begin in_op = 1; armed = 0; served = 0; end
        end else if (served) begin
          if (!req) in_op = 0;
        end else if (!req) begin
          in_op = 0;
        end else if (!armed) begin
          if (!old_deb) begin armed = 1; wait_n = 0; end
        end else if (old_deb) begin
          capture(chaves, 1'b0);
        end else if (TO_ON && wait_n == T - 1) begin
          capture('0, 1'b1);
        end else begin
          wait_n++;
        end
        // button level changes after D consecutive synchronized samples that disagree
        if (s2_pre != deb_m) begin
          run_m++;
          if (run_m == D) begin deb_m = s2_pre; run_m = 0; end
        end else begin
          run_m = 0;
        end
        b2 = b1;
        b1 = botao;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int pronto_cnt = 0;

  initial begin : monitor
    logic [48:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("pronto", {63'd0, pronto}, {63'd0, pulse});
        chk("parar", {63'd0, parar}, {63'd0, req && !(in_op && (pulse || served))});
        chk("expirou", {63'd0, expirou}, {63'd0, exp_m});
        chk("dado", {48'd0, dado}, {48'd0, dado_m});
        if (pronto === 1'b1) begin
          pronto_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: pronto at cycle %0d, expected none", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("sb_cycle", 64'(cyc), {32'd0, e[48:17]});
            chk("sb_expirou", {63'd0, expirou}, {63'd0, e[16]});
            chk("sb_dado", {48'd0, dado}, {48'd0, e[15:0]});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_pronto(input int max, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (pronto === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    bit           ok;
    int           c, at, cnt0;
    logic [W-1:0] v, old;

    rst_n = 1'b0; req = 1'b0; botao = 1'b0; chaves = '0;
    tick();
    mon_en = 1'b1;
    tick();
    chk("rst_dado", {48'd0, dado}, 64'd0);
    chk("rst_pronto", {63'd0, pronto}, 64'd0);
    chk("rst_expirou", {63'd0, expirou}, 64'd0);
    chk("rst_parar", {63'd0, parar}, 64'd0);
    rst_n = 1'b1;
    ticks(3);

    // basic clean press
    chaves = 16'hA5C3; req = 1'b1;
    tick();
    chk("basic_parar_wait", {63'd0, parar}, 64'd1);
    ticks(2);
    c = cyc; botao = 1'b1;
    wait_pronto(20, ok, at);
    chk("basic_seen", {63'd0, ok}, 64'd1);
    chk("basic_latency", 64'(at - c), 64'd7);
    chk("basic_dado", {48'd0, dado}, 64'hA5C3);
    tick();
    chk("basic_parar_after", {63'd0, parar}, 64'd0);
    // req held after pronto: release and press again, no second capture
    cnt0 = pronto_cnt; botao = 1'b0;
    ticks(10);
    botao = 1'b1;
    ticks(15);
    chk("fim_no_second", 64'(pronto_cnt - cnt0), 64'd0);
    chk("fim_parar", {63'd0, parar}, 64'd0);
    req = 1'b0; botao = 1'b0;
    ticks(10);

    // bouncy press
    v = 16'($urandom); chaves = v; req = 1'b1;
    ticks(3);
    cnt0 = pronto_cnt;
    for (int i = 0; i < 10; i++) begin
      botao = ~botao;
      tick();
    end
    c = cyc; botao = 1'b1;
    wait_pronto(30, ok, at);
    chk("bounce_seen", {63'd0, ok}, 64'd1);
    chk("bounce_latency", 64'(at - c), 64'd7);
    tick();
    chk("bounce_once", 64'(pronto_cnt - cnt0), 64'd1);
    chk("bounce_dado", {48'd0, dado}, {48'd0, v});
    botao = 1'b0; req = 1'b0;
    ticks(10);

    // button already held when req rises
    botao = 1'b1;
    ticks(10);
    v = 16'($urandom); chaves = v; req = 1'b1; cnt0 = pronto_cnt;
    ticks(20);
    tick();
    chk("held_no_pronto", 64'(pronto_cnt - cnt0), 64'd0);
    botao = 1'b0;
    ticks(10);
    c = cyc; botao = 1'b1;
    wait_pronto(20, ok, at);
    chk("held_seen", {63'd0, ok}, 64'd1);
    chk("held_latency", 64'(at - c), 64'd7);
    chk("held_dado", {48'd0, dado}, {48'd0, v});
    tick();
    botao = 1'b0; req = 1'b0;
    ticks(10);

    // abort while waiting for the press
    old = dado; cnt0 = pronto_cnt;
    chaves = ~old; req = 1'b1;
    ticks(6);
    req = 1'b0;
    ticks(10);
    chk("abort_no_pronto", 64'(pronto_cnt - cnt0), 64'd0);
    chk("abort_dado", {48'd0, dado}, {48'd0, old});

    // no press at all: timeout or indefinite wait
    chaves = 16'h1234; c = cyc; req = 1'b1; cnt0 = pronto_cnt;
    if (TO_ON) begin
      wait_pronto(40, ok, at);
      chk("to_seen", {63'd0, ok}, 64'd1);
      chk("to_latency", 64'(at - c), 64'd22);
      chk("to_expirou", {63'd0, expirou}, 64'd1);
      chk("to_dado", {48'd0, dado}, 64'd0);
    end else begin
      ticks(100);
      chk("noto_no_pronto", 64'(pronto_cnt - cnt0), 64'd0);
      chk("noto_parar", {63'd0, parar}, 64'd1);
    end
    tick();
    req = 1'b0;
    ticks(5);

    // capture something, then reset in the middle of a wait
    chaves = 16'hBEEF; req = 1'b1;
    ticks(3);
    botao = 1'b1;
    wait_pronto(20, ok, at);
    chk("pre_rst_seen", {63'd0, ok}, 64'd1);
    tick();
    botao = 1'b0; req = 1'b0;
    ticks(10);
    req = 1'b1;
    ticks(4);
    rst_n = 1'b0;
    tick();
    chk("midrst_dado", {48'd0, dado}, 64'd0);
    chk("midrst_parar", {63'd0, parar}, 64'd1);
    rst_n = 1'b1; req = 1'b0;
    ticks(5);

    // randomized operations, checked by the model and scoreboard
    for (int n = 0; n < 30; n++) begin
      chaves = 16'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        botao = 1'b1;
        ticks($urandom_range(2, 12));
        botao = 1'b0;
        ticks($urandom_range(0, 8));
      end
      req = 1'b1;
      ticks($urandom_range(0, 25));
      if ($urandom_range(0, 3) == 0) begin
        req = 1'b0;
        ticks(8);
      end else begin
        for (int i = 0; i < int'($urandom_range(0, 6)); i++) begin
          botao = ~botao;
          tick();
        end
        botao = 1'b1;
        if ($urandom_range(0, 1) == 1) chaves = 16'($urandom);
        ticks(12);
        botao = 1'b0;
        ticks($urandom_range(0, 5));
        req = 1'b0;
        ticks(8);
      end
    end

    ticks(5);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
